// File: rtl/bus_arbiter2.sv
// -----------------------------------------------------------------------------
// bus_arbiter2
// Two-requester bus arbiter with a bounded ownership time.
//
// A requester keeps the bus while it holds its request. If the other side is
// also waiting, ownership is handed over after MAX_HOLD consecutive owned
// cycles. Handing over in that case raises the one-cycle 'handover' pulse.
// While a side owns the bus, its data and rw flag are registered onto the bus
// outputs.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   : if both sides request while idle, the grant goes to the side
//               that did not own the bus last. A last_owner register tracks
//               this side.
//   undefined : if both sides request while idle, side 0 always wins.
//
// Parameters:
//   SIGNAL_WIDTH  width of the data paths (default 8)
//   MAX_HOLD      maximum consecutive owned cycles while contended (1..15)
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   req0, req1          level-held bus requests
//   data0_in, data1_in  requester write data
//   rw0, rw1            requester read(1)/write(0) flag
//   gnt0, gnt1          grants (one-hot or both low), decoded from state reg
//   bus_data            registered data of the current owner
//   bus_rw              registered rw of the current owner, 1 when idle
//   bus_valid           high while either requester owns the bus
//   handover            one-cycle pulse on a forced ownership change
// -----------------------------------------------------------------------------
module bus_arbiter2 #(
    parameter int SIGNAL_WIDTH = 8,
    parameter int MAX_HOLD     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [SIGNAL_WIDTH-1:0] data0_in,
    input  logic [SIGNAL_WIDTH-1:0] data1_in,
    input  logic                    rw0,
    input  logic                    rw1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic [SIGNAL_WIDTH-1:0] bus_data,
    output logic                    bus_rw,
    output logic                    bus_valid,
    output logic                    handover
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // The hold counter saturates at this value. Reaching it while the other
    // side waits triggers the forced handover.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t                  state_q, state_d;
    logic [3:0]              hold_cnt_q, hold_cnt_d;
    logic [SIGNAL_WIDTH-1:0] bus_data_q, bus_data_d;
    logic                    bus_rw_q, bus_rw_d;
    logic                    handover_q, handover_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                    last_owner_q, last_owner_d;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        handover_d = 1'b0;
        bus_data_d = bus_data_q;
        bus_rw_d   = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = last_owner_q ? OWN0 : OWN1;
`else
                    state_d = OWN0;
`endif
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                bus_data_d = data0_in;
                bus_rw_d   = rw0;
                // A voluntary release takes priority over the forced handover.
                // In that case no pulse is raised.
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (req1 && (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = OWN1;
                    handover_d = 1'b1;
                end
            end
            OWN1: begin
                bus_data_d = data1_in;
                bus_rw_d   = rw1;
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (req0 && (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = OWN0;
                    handover_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state entry restarts the count. Staying in an owned state
        // counts up to HOLD_LAST and then stays there.
        if (state_d != state_q) begin
            hold_cnt_d = 4'd0;
        end else if ((state_q != IDLE) && (hold_cnt_q < HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end

`ifdef ARB_ROUND_ROBIN_EN
        if (state_d != state_q) begin
            if (state_d == OWN0) begin
                last_owner_d = 1'b0;
            end else if (state_d == OWN1) begin
                last_owner_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= 4'd0;
            bus_data_q <= '0;
            bus_rw_q   <= 1'b1;
            handover_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            bus_data_q <= bus_data_d;
            bus_rw_q   <= bus_rw_d;
            handover_q <= handover_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Grants and valid are decoded straight from the state register. There is
    // no combinational path from the requests.
    assign gnt0      = (state_q == OWN0);
    assign gnt1      = (state_q == OWN1);
    assign bus_valid = (state_q != IDLE);
    assign bus_data  = bus_data_q;
    assign bus_rw    = bus_rw_q;
    assign handover  = handover_q;

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter SIGNAL_WIDTH, default 8: width of each data path.
REQ-002 Parameter MAX_HOLD, default 4, legal range 1..15: maximum consecutive owned cycles before forced handover when the other requester waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  bus request from requester 0 / 1, level-held.
REQ-006 data0_in, data1_in  input  SIGNAL_WIDTH each  requester write data.
REQ-007 rw0, rw1  input  1 each  requester read(1)/write(0) flag.
REQ-008 gnt0, gnt1  output  1 each  registered grant, one-hot or both low.
REQ-009 bus_data  output  SIGNAL_WIDTH  registered data of current owner.
REQ-010 bus_rw  output  1  registered rw of current owner; 1 when idle.
REQ-011 bus_valid  output  1  high while a requester owns the bus.
REQ-012 handover  output  1  one-cycle pulse on any forced (MAX_HOLD) ownership change.

Function
REQ-013 States IDLE, OWN0, OWN1; the state register is the sole source of gnt0/gnt1/bus_valid.
REQ-014 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> per REQ-020; none -> IDLE.
REQ-015 OWNx with reqx low: other req high -> OWN(other) directly; else -> IDLE.
REQ-016 OWNx with reqx high: stay, unless hold_cnt == MAX_HOLD-1 and other req high -> OWN(other) with handover pulse.
REQ-017 Grant latency: req sampled at edge N, gnt visible after edge N; no combinational path req->gnt.
REQ-018 hold_cnt: 4 bits; cleared on every state entry; increments each owned cycle; saturates at MAX_HOLD-1; never wraps.
REQ-019 bus_data/bus_rw register the owner's data/rw every owned cycle; in IDLE bus_data holds its last value, bus_rw=1.
REQ-020 Simultaneous req0/req1 in IDLE: resolved per Configuration.
REQ-021 Owner drop and forced-handover condition in the same cycle: treated as REQ-015 (no handover pulse).
REQ-022 MAX_HOLD=1 with both requesting: ownership alternates every cycle, handover high every cycle.

Reset
REQ-023 rst_n low: immediately state=IDLE, gnt0=gnt1=0, bus_valid=0, bus_data=0, bus_rw=1, handover=0, hold_cnt=0, last_owner=1.
REQ-024 Reset mid-ownership drops the grant asynchronously; first grant after release follows REQ-017 from the first sampling edge.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: simultaneous IDLE requests grant the port not equal to last_owner; last_owner updates on every ownership entry.
REQ-026 Macro ARB_ROUND_ROBIN_EN undefined: simultaneous IDLE requests always grant port 0; last_owner register absent; MAX_HOLD handover still applies.

Verification
REQ-027 Reset, req0=1 data0_in=8'hA5 rw0=0 -> after 1 edge gnt0=1, bus_valid=1; after 2 edges bus_data=8'hA5, bus_rw=0.
REQ-028 req0 held, req1 raised at cycle 2, MAX_HOLD=4 -> gnt0 for 4 cycles, then gnt1=1 with handover=1 for one cycle.
REQ-029 With ARB_ROUND_ROBIN_EN, owner 0 releases to IDLE, both req together -> gnt1; without macro -> gnt0.
REQ-030 req1 owner drops while req0 high -> next edge gnt0=1, gnt1=0, handover=0, no IDLE cycle.
REQ-031 rst_n pulsed low mid-OWN1 between edges -> gnt1, bus_valid fall without clock edge; bus_data=0, bus_rw=1.
REQ-032 MAX_HOLD=1, both held for 6 cycles -> gnt alternates 0,1,0,1,0,1 after first grant, handover high each alternation.
